// File: rtl/regfile_dump_ctrl.sv
// Register-bank dump sequencer: walks an inclusive address range, reading one
// register per beat and presenting it on a valid/ready stream.
module regfile_dump_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 5,
  parameter int NB_REG     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADD_WIDTH-1:0]  first_add_i,
  input  logic [ADD_WIDTH-1:0]  last_add_i,
  output logic [ADD_WIDTH-1:0]  rs_add_o,
  input  logic [DATA_WIDTH-1:0] rs_data_i,
  output logic [DATA_WIDTH-1:0] dump_data_o,
  output logic [ADD_WIDTH-1:0]  dump_add_o,
  output logic                  dump_valid_o,
  input  logic                  dump_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_DONE,
    S_ERR
  } state_t;

  state_t                r_state, w_next;
  logic [ADD_WIDTH-1:0]  r_cur_add;
  logic [ADD_WIDTH-1:0]  r_last_add;
  logic [ADD_WIDTH-1:0]  r_dump_add;
  logic [DATA_WIDTH-1:0] r_dump_data;

  logic w_range_bad;
  logic w_hs;
  logic w_at_last;

  // Range is rejected when reversed or when it runs past the bank.
  assign w_range_bad = (first_add_i > last_add_i) || (int'(last_add_i) >= NB_REG);
  assign w_hs        = (r_state == S_SEND) && dump_ready_i;
  assign w_at_last   = (r_cur_add == r_last_add);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start_i) w_next = w_range_bad ? S_ERR : S_READ;
      S_READ: w_next = abort_i ? S_IDLE : S_SEND;
      S_SEND: begin
        if (abort_i)     w_next = S_IDLE;
        else if (w_hs)   w_next = w_at_last ? S_DONE : S_READ;
      end
      S_DONE: w_next = S_IDLE;
      S_ERR:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_cur_add   <= '0;
      r_last_add  <= '0;
      r_dump_add  <= '0;
      r_dump_data <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (start_i) begin
          r_last_add <= last_add_i;
          if (!w_range_bad) r_cur_add <= first_add_i;
        end
        S_READ: if (!abort_i) begin
          r_dump_data <= rs_data_i;
          r_dump_add  <= r_cur_add;
        end
        // Increment only on a non-final accepted beat, so cur_add never passes last.
        S_SEND: if (w_hs && !abort_i && !w_at_last) r_cur_add <= r_cur_add + 1'b1;
        default: ;
      endcase
    end
  end

  assign rs_add_o     = r_cur_add;
  assign dump_data_o  = r_dump_data;
  assign dump_add_o   = r_dump_add;
  assign dump_valid_o = (r_state == S_SEND);
  assign busy_o       = (r_state != S_IDLE);
  // An abort landing in the completion cycle cancels the pulse.
  assign done_o       = (r_state == S_DONE) && !abort_i;
  assign err_o        = (r_state == S_ERR);

endmodule

// File: doc/regfile_dump_ctrl.md
REGFILE_DUMP_CTRL -- requirements
Module: regfile_dump_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter ADD_WIDTH, default 5, register address width.
REQ-003 SHALL have parameter NB_REG, default 32, number of registers in the bank.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  asynchronous, active-low reset.
REQ-006 start_i  input  1  request a dump; sampled only in IDLE.
REQ-007 abort_i  input  1  cancel dump in progress.
REQ-008 first_add_i  input  ADD_WIDTH  first register address of dump range.
REQ-009 last_add_i  input  ADD_WIDTH  last register address of dump range, inclusive.
REQ-010 rs_add_o  output  ADD_WIDTH  read address driven to register bank read port.
REQ-011 rs_data_i  input  DATA_WIDTH  combinational read data returned by register bank for rs_add_o.
REQ-012 dump_data_o  output  DATA_WIDTH  registered data beat.
REQ-013 dump_add_o  output  ADD_WIDTH  address of the register in dump_data_o.
REQ-014 dump_valid_o  output  1  beat valid.
REQ-015 dump_ready_i  input  1  sink accepts beat.
REQ-016 busy_o  output  1  high in any state other than IDLE.
REQ-017 done_o  output  1  one-cycle pulse at normal completion.
REQ-018 err_o  output  1  one-cycle pulse on rejected range.

Function
REQ-019 States SHALL be IDLE, READ, SEND, DONE, ERR.
REQ-020 IDLE + start_i=1: latch first/last; if first>last or last>=NB_REG -> ERR, else cur_add<=first -> READ.
REQ-021 IDLE + start_i=0 SHALL remain IDLE; start_i outside IDLE SHALL be ignored.
REQ-022 READ: rs_add_o=cur_add; at edge capture rs_data_i into dump_data_o, cur_add into dump_add_o -> SEND; one cycle only.
REQ-023 SEND: dump_valid_o=1; dump_data_o/dump_add_o SHALL stay stable until handshake (valid & ready at rising edge).
REQ-024 SEND handshake with cur_add==last -> DONE; otherwise cur_add<=cur_add+1 -> READ.
REQ-025 SEND without ready SHALL hold indefinitely, no timeout.
REQ-026 DONE: done_o=1 for exactly one cycle -> IDLE.
REQ-027 ERR: err_o=1 for exactly one cycle, no beat emitted -> IDLE.
REQ-028 Latency: start at edge N -> READ during cycle N+1 -> first valid beat from edge N+2; min 2 cycles/beat; total for k regs with ready held high = 2k+1 cycles from start to done pulse.
REQ-029 first==last SHALL produce exactly one beat then done.
REQ-030 cur_add SHALL never exceed last nor wrap; no increment past last.
REQ-031 abort_i=1 in READ/SEND/DONE SHALL go IDLE at next edge, drop dump_valid_o, suppress done_o; abort in IDLE/ERR has no effect beyond normal flow.
REQ-032 abort_i and handshake on same edge: abort wins, beat counted as delivered, no done_o.
REQ-033 rs_add_o outside READ SHALL hold cur_add (no glitch-driven semantics; bank is read-only from this block).
REQ-034 Address 0 SHALL be dumped as whatever the bank returns (bank forces 0).

Reset
REQ-035 rst_i=0 SHALL immediately force IDLE, cur_add=0, rs_add_o=0, dump_data_o=0, dump_add_o=0, dump_valid_o=0, busy_o=0, done_o=0, err_o=0.
REQ-036 Reset mid-dump SHALL discard the dump; no done_o/err_o after release.
REQ-037 First start SHALL be honoured on the first rising edge after rst_i returns to 1.

Verification
REQ-038 Bank preloaded x1=0x11111111, x3=0x22222222; start first=1,last=3, ready=1 -> beats (1,0x11111111),(2,0),(3,0x22222222), done_o pulse 7 cycles after start.
REQ-039 first=4,last=4, ready held 0 for 5 cycles -> single beat add 4 held stable 5 cycles, accepted when ready=1, then done_o.
REQ-040 first=5,last=2 -> err_o pulse one cycle after start, dump_valid_o never asserted, busy_o 1 cycle.
REQ-041 Dump 0..31 with abort_i at beat 10 in SEND -> IDLE next edge, valid low, no done_o; new start 0..0 completes normally.
REQ-042 rst_i pulsed low during SEND of first=0,last=31 -> all outputs 0 asynchronously, IDLE after release, start repeated -> full 32-beat dump ending address 31.
REQ-043 start_i asserted while busy -> ignored; dump range and beat count unchanged.
